// File: rtl/truth_table_capture.sv
// Truth-table capture engine: sweeps every input code of a combinational or
// pipelined function under test, records its response per code and compares
// the recorded table against a golden table.
module truth_table_capture #(
    parameter int unsigned           N_IN     = 5,
    parameter int unsigned           LATENCY  = 1,
    parameter logic [2**N_IN-1:0]    EXPECTED = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     resp,
    output logic [N_IN-1:0]          in_drv,
    output logic                     busy,
    output logic                     done,
    output logic [2**N_IN-1:0]       table_out,
    output logic [N_IN:0]            mismatch_cnt,
    output logic                     pass
);

    localparam int unsigned     NumEntries = 2**N_IN;
    localparam int unsigned     CntW       = N_IN + 1;
    localparam logic [N_IN-1:0] IdxMax     = '1;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StDrain,
        StDone
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [N_IN-1:0]       r_in_drv;
    logic [NumEntries-1:0] r_table;
    logic [CntW-1:0]       r_cnt;
    logic                  r_last_cap;

    logic                  w_start_acc;
    logic                  w_drv_vld;
    logic                  w_cap_vld;
    logic [N_IN-1:0]       w_cap_idx;

    assign w_start_acc = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_drv_vld   = (r_state == StDrive);

    // Capture-point alignment: index/valid travel LATENCY stages behind in_drv.
    if (LATENCY == 0) begin : g_comb
        assign w_cap_vld = w_drv_vld;
        assign w_cap_idx = r_in_drv;
    end else begin : g_pipe
        logic [LATENCY-1:0] r_pipe_vld;
        logic [N_IN-1:0]    r_pipe_idx [LATENCY];

        // Shift the driven index and its valid flag down the delay line.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pipe_vld <= '0;
                for (int unsigned k = 0; k < LATENCY; k++) begin
                    r_pipe_idx[k] <= '0;
                end
            end else begin
                r_pipe_vld[0] <= w_drv_vld;
                r_pipe_idx[0] <= r_in_drv;
                for (int unsigned k = 1; k < LATENCY; k++) begin
                    r_pipe_vld[k] <= r_pipe_vld[k-1];
                    r_pipe_idx[k] <= r_pipe_idx[k-1];
                end
            end
        end

        assign w_cap_vld = r_pipe_vld[LATENCY-1];
        assign w_cap_idx = r_pipe_idx[LATENCY-1];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DRAIN exits one edge after the last index is captured.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: if (start)                 w_state_next = StDrive;
            StDrive:        if (r_in_drv == IdxMax)    w_state_next = StDrain;
            StDrain:        if (r_last_cap)            w_state_next = StDone;
            default:                                   w_state_next = StIdle;
        endcase
    end

    // Input driver and result capture. The pipeline is empty whenever a start
    // can be accepted, so clearing and capturing never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_drv   <= '0;
            r_table    <= '0;
            r_cnt      <= '0;
            r_last_cap <= 1'b0;
        end else if (w_start_acc) begin
            r_in_drv   <= '0;
            r_table    <= '0;
            r_cnt      <= '0;
            r_last_cap <= 1'b0;
        end else begin
            // Natural wrap returns in_drv to 0 on the DRIVE-to-DRAIN edge.
            if (w_drv_vld) begin
                r_in_drv <= r_in_drv + N_IN'(1);
            end
            if (w_cap_vld) begin
                r_table[w_cap_idx] <= resp;
                // At most 2^N_IN increments, which CntW bits always hold.
                if (resp != EXPECTED[w_cap_idx]) begin
                    r_cnt <= r_cnt + CntW'(1);
                end
                if (w_cap_idx == IdxMax) begin
                    r_last_cap <= 1'b1;
                end
            end
        end
    end

    assign in_drv       = r_in_drv;
    assign busy         = (r_state == StDrive) || (r_state == StDrain);
    assign done         = (r_state == StDone);
    assign table_out    = r_table;
    assign mismatch_cnt = r_cnt;
    assign pass         = done && (r_cnt == '0);

endmodule

// File: doc/truth_table_capture.md
TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 SHALL have parameter N_IN, default 5: width of the input vector driven to the function under test; the table holds 2^N_IN entries.
REQ-002 SHALL have parameter LATENCY, default 1: clock cycles from a change of in_drv to a valid resp; legal range 0..7.
REQ-003 SHALL have parameter EXPECTED, default 0, width 2^N_IN: golden truth table; bit i is the required output for input i.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a sweep.
REQ-007 SHALL have port resp  input  1  output of the function under test.
REQ-008 SHALL have port in_drv  output  N_IN  input vector driven to the function under test.
REQ-009 SHALL have port busy  output  1  high while a sweep or drain is in progress.
REQ-010 SHALL have port done  output  1  high while results are valid, held until the next start.
REQ-011 SHALL have port table_out  output  2^N_IN  captured truth table; bit i holds resp for in_drv=i.
REQ-012 SHALL have port mismatch_cnt  output  N_IN+1  count of bits where table_out differs from EXPECTED.
REQ-013 SHALL have port pass  output  1  high when done=1 and mismatch_cnt=0.

Function
REQ-014 SHALL implement an FSM with states IDLE, DRIVE, DRAIN and DONE.
REQ-015 SHALL accept start only in IDLE or DONE; start SHALL be ignored in DRIVE and DRAIN.
REQ-016 On an accepted start at edge E0, the block SHALL enter DRIVE, set in_drv=0, busy=1 and done=0, and clear table_out and mismatch_cnt.
REQ-017 In DRIVE, in_drv SHALL increment by 1 at each rising edge.
REQ-018 At the edge where in_drv=2^N_IN-1 would increment, in_drv SHALL return to 0 and the FSM SHALL enter DRAIN.
REQ-019 Capture timing: resp for index i SHALL be sampled at the (LATENCY+1)th rising edge after in_drv first presents i.
REQ-020 Capture tracking SHALL use an index/valid delay pipeline of depth LATENCY; with LATENCY=0, resp is sampled combinationally in the same cycle.
REQ-021 Each capture SHALL write bit i of table_out and increment mismatch_cnt when resp != EXPECTED[i].
REQ-022 Captures SHALL be in-order, exactly one per index, with none lost or duplicated across the DRIVE-to-DRAIN boundary.
REQ-023 DRAIN SHALL last until the capture of index 2^N_IN-1, which occurs at edge E(2^N_IN+LATENCY).
REQ-024 At edge E(2^N_IN+LATENCY+1) the FSM SHALL enter DONE with busy=0, done=1, and pass=(mismatch_cnt==0).
REQ-025 pass SHALL be 0 whenever done=0.
REQ-026 In DONE, table_out, mismatch_cnt and pass SHALL hold; in_drv SHALL stay 0.
REQ-027 A start received in DONE SHALL restart per REQ-016.
REQ-028 mismatch_cnt SHALL be wide enough for 2^N_IN mismatches and SHALL never wrap.
REQ-029 A start coincident with the last DRAIN capture SHALL be ignored.

Reset
REQ-030 Assertion of rst_n=0 SHALL immediately, without waiting for clk, force IDLE, in_drv=0, busy=0, done=0, pass=0, table_out=0, mismatch_cnt=0 and clear the capture pipeline.
REQ-031 Reset mid-sweep SHALL abandon the sweep; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-032 N_IN=5, LATENCY=0, resp=in_drv[0], EXPECTED=32'hAAAAAAAA, start pulse -> done=1 at E33, table_out=32'hAAAAAAAA, mismatch_cnt=0, pass=1.
REQ-033 N_IN=5, LATENCY=1, resp=registered &in_drv, EXPECTED=32'h80000000 -> done=1 at E34, table_out=32'h80000000, pass=1; in_drv steps 0..31 on consecutive edges.
REQ-034 Same setup as REQ-033 with EXPECTED=32'h80000001 -> table_out=32'h80000000, mismatch_cnt=1, pass=0.
REQ-035 resp tied to 1, EXPECTED=0 -> table_out=32'hFFFFFFFF, mismatch_cnt=32 with no wrap, pass=0.
REQ-036 Start pulses at E5 and E20 of a sweep -> both ignored, done still at E33; a start in DONE -> done=0, table_out=0, and the sweep repeats.
REQ-037 rst_n=0 asynchronously at E10+3 ns -> all outputs 0 before the next edge; after release with no start, the block remains in IDLE with in_drv=0.
